// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the barrel shifter datapath and its round-robin front end.
// Op codes outside op_e (5..7) are pass-through.
package barrel_shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_SRL = 3'd0,
    OP_SRA = 3'd1,
    OP_SLL = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } op_e;

endpackage

// File: rtl/barrel_shift.sv
// Combinational barrel shifter: logical/arithmetic shifts and rotates by a
// variable amount; unknown op codes pass the data through.
module barrel_shift
  import barrel_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]    data,
  input  logic [SW-1:0]   shift,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    result
);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] ror_wide;
  logic [2*N-1:0] rol_wide;

  // Rotates come from a doubled word, so a zero amount needs no special case.
  assign doubled  = {data, data};
  assign ror_wide = doubled >> shift;
  assign rol_wide = doubled << shift;

  always_comb begin
    result = data;
    case (op_e'(op))
      OP_SRL:  result = data >> shift;
      OP_SRA:  result = N'($signed(data) >>> shift);
      OP_SLL:  result = data << shift;
      OP_ROR:  result = ror_wide[N-1:0];
      OP_ROL:  result = rol_wide[2*N-1:N];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/barrel_shift_arb.sv
// Round-robin sharing of one barrel shifter among R requesters, with a single
// registered response stage carrying the requester index and op code.
module barrel_shift_arb
  import barrel_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4,
  localparam int SW  = $clog2(N),
  localparam int IDW = $clog2(R)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  output logic [R-1:0]      req_ready,
  input  logic [R*N-1:0]    req_data,
  input  logic [R*SW-1:0]   req_shift,
  input  logic [R*OP_W-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [OP_W-1:0]   rsp_op
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both 1.
  // Producers hold valid and payload until ready; ready may depend on valid.
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic [N-1:0]    sel_data;
  logic [SW-1:0]   sel_shift;
  logic [OP_W-1:0] sel_op;
  logic [N-1:0]    shift_result;

  // Search starts one past the last winner; win stays 0 when idle so the
  // shifter always sees requester 0's defined inputs.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= R; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % R]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % R);
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = found && can_accept;
  assign req_ready  = accept ? (R'(1) << win) : '0;

  assign sel_data  = req_data[win*N +: N];
  assign sel_shift = req_shift[win*SW +: SW];
  assign sel_op    = req_op[win*OP_W +: OP_W];

  barrel_shift #(.N(N), .SW(SW)) u_shift (
    .data   (sel_data),
    .shift  (sel_shift),
    .op     (sel_op),
    .result (shift_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_op    <= '0;
      ptr       <= IDW'(R - 1);
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shift_result;
      rsp_id    <= win;
      rsp_op    <= sel_op;
      ptr       <= win;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/barrel_shift_arb.md
Name: barrel_shift_arb

Overview:
Round-robin arbiter and sequencer that shares one combinational barrel_shift datapath between R independent requesters. Each requester presents {data, shift amount, op} on a valid/ready handshake. The arbiter grants at most one request per cycle and drives the shared shifter with it. The result is registered and returned on a single response channel, tagged with the requester index, with full back-pressure.

Parameters:
N, 8, data width in bits; shift amount width is SW = $clog2(N)
R, 4, number of requesters, at least 2; IDW = $clog2(R)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  R  per-requester request valid
req_ready  output  R  per-requester accept, one-hot or zero
req_data  input  R*N  requester i payload at bits [i*N +: N]
req_shift  input  R*SW  requester i shift amount at [i*SW +: SW]
req_op  input  R*3  requester i op code at [i*3 +: 3]
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accept
rsp_data  output  N  shifted result
rsp_id  output  IDW  index of the requester that produced rsp_data
rsp_op  output  3  op code of the returned result

Behaviour:
- Reset (async, active-high): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0, priority pointer ptr=R-1 so requester 0 has highest priority first. req_ready is combinational and therefore 0 while rsp_valid=0 and no request is valid.
- Op codes: 0 SRL, 1 SRA, 2 SLL, 3 ROR, 4 ROL, 5..7 pass-through (result = data). Shift amount 0 returns data unchanged for every op.
- Output stage: single register. can_accept = !rsp_valid | rsp_ready.
- Arbitration is combinational and round-robin. Search order is ptr+1, ptr+2, … modulo R; the first requester with req_valid=1 is the winner.
- req_ready[winner] = can_accept; all other req_ready bits are 0. Zero requests means req_ready = 0.
- Accept (req_valid[i] & req_ready[i]):
  - the winner's fields are muxed into the barrel_shift instance;
  - on the next edge rsp_data, rsp_id and rsp_op are loaded and rsp_valid=1;
  - ptr is set to the winner.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput: 1 result per cycle while rsp_ready=1.
- Response handshake:
  - rsp_valid & rsp_ready with no new accept: rsp_valid drops to 0 next cycle.
  - Simultaneous drain and accept: the register is overwritten with the new result and rsp_valid stays 1, giving no bubble.
- Back-pressure: rsp_valid=1 & rsp_ready=0 holds rsp_* stable, forces all req_ready to 0 and freezes ptr.
- Requesters hold valid and payload stable until ready. The arbiter does not check this; an invalid requester is simply skipped.
- ptr changes only on accept, never on idle cycles.
- Reset mid-transfer: an in-flight response is discarded immediately (rsp_valid falls asynchronously). After release, priority starts again at requester 0.
- No X propagation: the mux selects requester 0 when idle, so the shifter always sees defined inputs.

Decomposition:
- Package barrel_shift_pkg holds:
  - typedef enum logic [2:0] op_e {OP_SRL=0, OP_SRA=1, OP_SLL=2, OP_ROR=3, OP_ROL=4};
  - localparam OP_W = 3.
- Shared with the existing barrel_shift datapath and its bench.
- One sub-module: the existing barrel_shift, instantiated once with .N(N).
- A small rr_arb function or sub-block (R-bit request vector, ptr → one-hot grant plus index) is natural and reusable.
- Everything else is flat.

Test Plan:
- N=8, R=4, req0 data=0xB4 shift=3 op=1 (SRA), rsp_ready=1 → req_ready=4'b0001 in the same cycle; next cycle rsp_valid=1, rsp_data=0xF6, rsp_id=0, rsp_op=1.
- Ops on 0x81 shift=1:
  - op3 (ROR) → 0xC0;
  - op4 (ROL) → 0x03;
  - op0 → 0x40;
  - op2 → 0x02;
  - op6 → 0x81.
  - Also shift=0, op4 → 0x81.
  - Compare all against a reference model over 10k random cycles, including random rsp_ready.
- All four req_valid=1, held continuously, rsp_ready=1 after reset → rsp_id sequence 0,1,2,3,0,… on back-to-back cycles, with rsp_valid never dropping.
- Back-pressure: rsp_valid=1, rsp_ready=0 for 5 cycles with req1 and req2 valid → req_ready=0 and rsp_data/rsp_id stable for all 5 cycles. Once rsp_ready=1, the next grant follows ptr order unchanged.
- Fairness: only req1 and req3 valid, last grant=1 → grants alternate 3,1,3,1. A newly raised req2 is then granted within 2 accepts.
- Reset mid-operation: assert rst while rsp_valid=1 → rsp_valid=0 before the next clock edge. After release, with req0 and req3 both valid, req0 is granted first.
